aes_frame_ctrl: RTL

AES_FRAME_CTRL -- requirements
Module: aes_frame_ctrl

---
 rtl/aes_frame_ctrl_pkg.sv | 16 +
 rtl/aes_frame_serializer.sv | 57 +++++
 rtl/aes_frame_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_frame_ctrl_pkg.sv
// Shared definitions for the AES frame controller: FSM encoding and framing constants.
package aes_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALF,
    S_RUN,
    S_WAIT,
    S_SEND,
    S_TXWAIT
  } state_t;

  localparam logic [7:0] FRAME_HDR       = 8'h02;
  localparam logic [4:0] BYTES_PER_BLOCK = 5'd16;

endpackage

// File: rtl/aes_frame_serializer.sv
// Holds the AES result, the byte index and the transmit byte mux.
// Define AES_FRAME_HDR_EN to prefix every block with the FRAME_HDR byte.
module aes_frame_serializer
  import aes_frame_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic [127:0] dout,
  input  logic         advance,
  input  logic         active,
  output logic [7:0]   tx_byte,
  output logic         last
);

  logic [127:0] result;
  logic [4:0]   idx;
  logic [7:0]   sel_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      idx    <= '0;
    end else if (capture) begin
      result <= dout;
      idx    <= '0;
    end else if (advance) begin
      idx <= idx + 5'd1;
    end
  end

`ifdef AES_FRAME_HDR_EN
  // idx 0 is the header slot, so result bytes live at idx 1..16.
  logic [4:0] data_idx;
  assign data_idx = idx - 5'd1;
  assign last     = (idx == BYTES_PER_BLOCK);

  always_comb begin
    sel_byte = '0;
    if (idx == 5'd0)
      sel_byte = FRAME_HDR;
    else if (data_idx < BYTES_PER_BLOCK)
      sel_byte = result[{data_idx[3:0], 3'b000} +: 8];
  end
`else
  assign last = (idx == BYTES_PER_BLOCK - 5'd1);

  always_comb begin
    sel_byte = '0;
    if (idx < BYTES_PER_BLOCK)
      sel_byte = result[{idx[3:0], 3'b000} +: 8];
  end
`endif

  assign tx_byte = active ? sel_byte : 8'h00;

endmodule

// File: rtl/aes_frame_ctrl.sv
// Collects two 64-bit UART packets into an AES block, runs the core and streams the result bytes.
// Optional AES_FRAME_HDR_EN adds a header byte in front of each transmitted block.
module aes_frame_ctrl
  import aes_frame_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [63:0]  rx_data,
  output logic         aes_start,
  output logic [127:0] aes_din,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         tx_send,
  output logic [7:0]   tx_byte,
  input  logic         tx_done,
  output logic         busy,
  output logic         err
);

  state_t       state, next_state;
  logic [127:0] block;
  logic         capture, advance, active, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (rx_valid) next_state = S_HALF;
      S_HALF:   if (rx_valid) next_state = S_RUN;
      S_RUN:    next_state = S_WAIT;
      S_WAIT:   if (aes_done) next_state = S_SEND;
      S_SEND:   next_state = S_TXWAIT;
      S_TXWAIT: if (tx_done) next_state = last ? S_IDLE : S_SEND;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    aes_start = 1'b0;
    tx_send   = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    active    = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE, S_HALF: busy = 1'b0;
      S_RUN:          aes_start = 1'b1;
      S_WAIT:         capture = aes_done;
      S_SEND: begin
        tx_send = 1'b1;
        active  = 1'b1;
      end
      S_TXWAIT: begin
        advance = tx_done;
        active  = 1'b1;
      end
      default:        busy = 1'b1;
    endcase
  end

  // Packets only land while assembling; anywhere else they are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block <= '0;
      err   <= 1'b0;
    end else if (rx_valid) begin
      if (state == S_IDLE)      block[63:0]   <= rx_data;
      else if (state == S_HALF) block[127:64] <= rx_data;
      else                      err           <= 1'b1;
    end
  end

  assign aes_din = block;

  aes_frame_serializer u_serializer (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .dout    (aes_dout),
    .advance (advance),
    .active  (active),
    .tx_byte (tx_byte),
    .last    (last)
  );

endmodule
